// File: rtl/seg7_pkg.sv
// seg7_pkg: shared segment patterns, digit codes and anode constants for
// the multiplexed seven-segment display blocks.
// Purely declarative: no latency, no flow control.
package seg7_pkg;

  // Active-high segment patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_U     = 7'h3E;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // All anodes off (anodes are active-low).
  localparam logic [3:0] ANODE_OFF = 4'b1111;

  // What a digit position shows: a 4-bit value, one of the letters, or nothing.
  typedef enum logic [1:0] {
    DK_NUM,
    DK_LET_U,
    DK_LET_D,
    DK_BLANK
  } digit_kind_e;

  typedef struct packed {
    digit_kind_e kind;
    logic [3:0]  val;
  } digit_code_t;

  function automatic digit_code_t num_code(input logic [3:0] v);
    digit_code_t c;
    c.kind = DK_NUM;
    c.val  = v;
    return c;
  endfunction

  function automatic digit_code_t kind_code(input digit_kind_e k);
    digit_code_t c;
    c.kind = k;
    c.val  = 4'd0;
    return c;
  endfunction

endpackage

// File: rtl/seg7_encode.sv
// seg7_encode: maps a digit code to an active-high {g,f,e,d,c,b,a} pattern.
// Latency: purely combinational.
// Backpressure: none.
// Ports: code (digit code in), pattern (7-bit active-high segments out).
module seg7_encode
  import seg7_pkg::*;
(
  input  digit_code_t code,
  output logic [6:0]  pattern
);

  always_comb begin
    pattern = SEG_BLANK;
    case (code.kind)
      DK_NUM: begin
        case (code.val)
          4'h0: pattern = SEG_0;
          4'h1: pattern = SEG_1;
          4'h2: pattern = SEG_2;
          4'h3: pattern = SEG_3;
          4'h4: pattern = SEG_4;
          4'h5: pattern = SEG_5;
          4'h6: pattern = SEG_6;
          4'h7: pattern = SEG_7;
          4'h8: pattern = SEG_8;
          4'h9: pattern = SEG_9;
          4'hA: pattern = SEG_A;
          4'hB: pattern = SEG_B;
          4'hC: pattern = SEG_C;
          4'hD: pattern = SEG_D;
          4'hE: pattern = SEG_E;
          4'hF: pattern = SEG_F;
          default: pattern = SEG_BLANK;
        endcase
      end
      DK_LET_U: pattern = SEG_U;
      DK_LET_D: pattern = SEG_D;
      default:  pattern = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_count_display.sv
// seg7_count_display: drives a 4-digit common-anode display with the counter
// value (digits 1:0) and direction letter (digit 3), latched once per frame.
// Latency: seg/an/dp registered, aligned with the registered digit index.
// Backpressure: none; inputs are sampled only at the end-of-frame snapshot.
// Ports: clk, rst_n (sync, active-low), count[3:0], dir, blank in;
//        seg[6:0] (active-low), dp, an[3:0] (one-hot active-low), frame_done out.
// Build option: define SEG7_HEX_DISPLAY_EN to show the count as one hex digit.
module seg7_count_display
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] count,
  input  logic       dir,
  input  logic       blank,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       frame_done
);

  localparam int              PW         = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(SCAN_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    digit_q, digit_d;
  logic [3:0]    sh_count_q, sh_count_d;
  logic          sh_dir_q, sh_dir_d;
  logic          sh_blank_q, sh_blank_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;
  logic          dp_q, dp_d;

  logic          tick;
  logic          snap;
  digit_code_t   code0, code1, disp_code;
  logic [6:0]    pattern;

  // Scan timing and snapshot.
  always_comb begin
    tick       = (presc_q == PRESC_LAST);
    snap       = tick && (digit_q == 2'd3);
    presc_d    = tick ? '0 : presc_q + PW'(1);
    digit_d    = tick ? digit_q + 2'd1 : digit_q;
    sh_count_d = sh_count_q;
    sh_dir_d   = sh_dir_q;
    sh_blank_d = sh_blank_q;
    if (snap) begin
      sh_count_d = count;
      sh_dir_d   = dir;
      sh_blank_d = blank;
    end
  end

  // Digit content. Built from the next-cycle index and shadow so the
  // registered outputs line up with digit_q, and the first cycle of the
  // digit0 slot already shows the freshly latched value.
  always_comb begin
`ifdef SEG7_HEX_DISPLAY_EN
    code0 = num_code(sh_count_d);
    code1 = kind_code(DK_BLANK);
`else
    if (sh_count_d >= 4'd10) begin
      code0 = num_code(sh_count_d - 4'd10);
      code1 = num_code(4'd1);
    end else begin
      code0 = num_code(sh_count_d);
      code1 = kind_code(DK_BLANK);
    end
`endif
    case (digit_d)
      2'd0:    disp_code = code0;
      2'd1:    disp_code = code1;
      2'd2:    disp_code = kind_code(DK_BLANK);
      default: disp_code = sh_dir_d ? kind_code(DK_LET_U) : kind_code(DK_LET_D);
    endcase
  end

  seg7_encode u_encode (
    .code    (disp_code),
    .pattern (pattern)
  );

  always_comb begin
    seg_d = ~pattern;
    an_d  = ~(4'b0001 << digit_d);
    dp_d  = 1'b1;
    if (sh_blank_d) begin
      seg_d = 7'h7F;
      an_d  = ANODE_OFF;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q    <= '0;
      digit_q    <= 2'd0;
      sh_count_q <= 4'd0;
      sh_dir_q   <= 1'b1;
      sh_blank_q <= 1'b1;
      seg_q      <= 7'h7F;
      an_q       <= ANODE_OFF;
      dp_q       <= 1'b1;
    end else begin
      presc_q    <= presc_d;
      digit_q    <= digit_d;
      sh_count_q <= sh_count_d;
      sh_dir_q   <= sh_dir_d;
      sh_blank_q <= sh_blank_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
      dp_q       <= dp_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign dp         = dp_q;
  // Decoded from registered scan state only; high in the snapshot cycle.
  assign frame_done = snap;

endmodule

// File: doc/seg7_count_display.md
Name: seg7_count_display

Overview:
- Display-side reader for the 4-bit up/down counter. Takes the live count value and the current count direction and drives a 4-digit, multiplexed, common-anode seven-segment display.
- Shows the decimal value on digits 1:0 and the direction letter on digit 3.
- Latches its inputs once per scan frame, so a digit never shows a value torn across a counter update.
- Sits between the counter block and the board display pins.

Parameters:
- SCAN_DIV, 100000, clk cycles each digit stays lit; minimum 2. Prescaler width is $clog2(SCAN_DIV).

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous, active-low reset
- count  input  4  counter value to display, 0..15
- dir  input  1  count direction; 1 = up, 0 = down
- blank  input  1  1 = display dark for the whole frame
- seg  output  7  segment cathodes {g,f,e,d,c,b,a}, active-low
- dp  output  1  decimal point, active-low
- an  output  4  digit anodes, one-hot active-low; an[0] is the rightmost digit
- frame_done  output  1  one-cycle pulse on each snapshot load

Behaviour:
- Reset:
  - All state updates on the clk edge where rst_n=0; no asynchronous path.
  - Output values: an=4'b1111, seg=7'b1111111, dp=1, frame_done=0.
  - Internal values: prescaler=0, digit index=0, shadow count=0, shadow dir=1, shadow blank=1. The display is dark until the first snapshot.
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps to 0.
  - tick=1 when prescaler==SCAN_DIV-1.
- Digit index:
  - 2-bit; increments on tick and wraps 3→0.
  - One frame = 4*SCAN_DIV cycles.
- Snapshot:
  - On the edge where tick=1 and digit index==3, load count, dir and blank into the shadow registers.
  - frame_done=1 in that same cycle.
  - Inputs are ignored at all other times. Mid-frame input changes take effect at the next frame only.
- Digit content, from shadow values only:
  - digit0 = shadow count mod 10.
  - digit1 = "1" if shadow count >= 10, otherwise blank.
  - digit2 = blank.
  - digit3 = 'U' if dir=1, 'd' if dir=0.
- Segment patterns, active-high gfedcba before output inversion:
  - Digits: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Letters: U=3E, d=5E. Blank=00.
  - seg = ~pattern.
- Anodes:
  - an = ~(1<<digit index), including for blank digits (their seg is 1111111).
  - When shadow blank=1: an=4'b1111 and seg=7'b1111111 for the whole frame.
- dp: 1 (off) at all times.
- Latency:
  - seg, an and dp are registered.
  - They reflect digit index and shadow values with 1-cycle latency.
  - The first cycle of each digit0 slot already uses the newly loaded shadow.
- Reset mid-frame: the scan restarts from digit0 with prescaler 0, and the display is dark until the next snapshot.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro: SEG7_HEX_DISPLAY_EN.
- Defined:
  - digit0 = hex value of the shadow count; digit1 is always blank.
  - Extra patterns: A=77, b=7C, C=39, d=5E, E=79, F=71.
- Undefined: decimal display as described above.
- Frame timing, snapshot and anode behaviour are identical in both builds.

Decomposition:
- Package seg7_pkg holds:
  - Segment pattern constants SEG_0..SEG_F, SEG_U, SEG_BLANK.
  - Digit-code typedef (4-bit value plus blank and letter codes).
  - ANODE_OFF constant.
- One combinational sub-module, seg7_encode, maps a digit code to a 7-bit active-high pattern. It is shared with future display blocks.
- Prescaler, scan counter, snapshot logic and output registers stay in the top module.

Test Plan:
All scenarios use SCAN_DIV=4, giving a 16-cycle frame.
- Reset held 3 cycles, then released with blank=1: an=1111, seg=1111111 and dp=1 throughout; frame_done pulses every 16 cycles, first pulse at cycle 15 after release.
- count=13, dir=1, blank=0, from one frame_done onward:
  - an=1110, seg=0110000 (3)
  - an=1101, seg=1111001 (1)
  - an=1011, seg=1111111 (blank)
  - an=0111, seg=1000001 (U)
- count changed 13→4, dir 1→0, while an=1101: that frame still shows 13 and U. Next frame shows digit0 seg=0011001, digit1 blank, digit3 seg=0100001 (d).
- count=0: digit0 seg=1000000, digit1 blank. count=15, dir=0: digits show "15" then 'd'. count=9→10 boundary: tens digit appears only in the frame after the snapshot.
- rst_n=0 for 1 cycle during the digit2 slot: on the next edge, outputs take reset values and prescaler and digit index are 0. The display stays dark until the snapshot 16 cycles later.
- SEG7_HEX_DISPLAY_EN defined, count=11: digit0 seg=0000011 (b), digit1 blank; count=15 gives digit0 seg=0001110 (F).
